// File: rtl/fir_sample_feeder_pkg.sv
// rtl/fir_sample_feeder_pkg.sv - shared types and constants for the FIR sample feeder
package fir_pkg;

    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
    localparam int          FP_BIAS  = 127;
    localparam int          SAMPLE_W = 16;
    localparam int          FP_W     = 32;

    typedef struct packed {
        logic                       last;
        logic signed [SAMPLE_W-1:0] data;
    } fifo_entry_t;

    // Only one sample is ever between the FIFO head and fir_in
    typedef enum logic [1:0] {
        EMPTY,
        CONV,
        STAGED
    } pop_state_t;

endpackage

// File: rtl/fir_sample_feeder_i16_to_fp32.sv
// rtl/fir_sample_feeder_i16_to_fp32.sv - two-stage exact int16 to float32 converter
module i16_to_fp32
    import fir_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic signed [SAMPLE_W-1:0] i_data,
    input  logic                       i_last,
    output logic                       o_valid,
    output logic [FP_W-1:0]            o_data,
    output logic                       o_last
);

    // 17 bits so that -32768 has a representable magnitude
    logic [16:0]     w_mag;
    logic            r_s1_valid;
    logic            r_s1_sign;
    logic            r_s1_last;
    logic [16:0]     r_s1_mag;
    logic [4:0]      w_pos;
    logic [22:0]     w_mant;
    logic [FP_W-1:0] w_fp;
    logic            r_s2_valid;
    logic            r_s2_last;
    logic [FP_W-1:0] r_s2_fp;

    assign w_mag = i_data[SAMPLE_W-1] ? (17'd0 - {1'b1, i_data}) : {1'b0, i_data};

    // Stage 1: split the sample into sign and magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mag   <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_sign  <= i_data[SAMPLE_W-1];
            r_s1_last  <= i_last;
            r_s1_mag   <= w_mag;
        end
    end

    // Leading-one search and normalisation; the hidden bit falls off the top of the 23-bit shift
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < 17; i++) begin
            if (r_s1_mag[i]) begin
                w_pos = 5'(i);
            end
        end
        w_mant = {6'd0, r_s1_mag} << (5'd23 - w_pos);
        if (r_s1_mag == '0) begin
            w_fp = FP_ZERO;
        end else begin
            w_fp = {r_s1_sign, 8'(FP_BIAS) + {3'b000, w_pos}, w_mant};
        end
    end

    // Stage 2: register the assembled float
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_fp    <= FP_ZERO;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_fp    <= w_fp;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_data  = r_s2_fp;
    assign o_last  = r_s2_last;

endmodule

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - buffers ADC samples and feeds them to the FIR as float32
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_data,
    input  logic                       s_last,
    input  logic                       fir_next,
    output logic [FP_W-1:0]            fir_in,
    output logic                       fir_stop,
    output logic                       fir_primed,
    output logic [PTR_W:0]             fill_level,
    output logic                       underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fifo_entry_t     r_mem [DEPTH];
    logic [PTR_W:0]  r_wr_ptr;
    logic [PTR_W:0]  r_rd_ptr;
    logic [PTR_W:0]  w_count;
    logic            w_wr_en;
    logic            w_empty;
    fifo_entry_t     w_head;

    pop_state_t      r_state;
    pop_state_t      w_next_state;
    logic            w_pop;
    logic            w_stage_wr;
    logic            w_take;

    logic            w_conv_valid;
    logic [FP_W-1:0] w_conv_fp;
    logic            w_conv_last;

    logic [FP_W-1:0] r_stg_fp;
    logic            r_stg_last;
    logic            w_stg_valid;
    logic [FP_W-1:0] w_stg_fp;
    logic            w_stg_last;

    logic [FP_W-1:0] r_fir_in;
    logic            r_fir_stop;
    logic            r_fir_primed;
    logic            r_underflow;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (w_count == '0);
    assign s_ready    = (w_count != FULL_CNT) && !r_fir_stop;
    assign w_wr_en    = s_valid && s_ready;
    assign w_head     = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign fill_level = w_count;

    // Sample storage; contents need no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= '{last: s_last, data: s_data};
        end
    end

    // FIFO pointers; the extra bit separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    i16_to_fp32 u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_pop),
        .i_data  (w_head.data),
        .i_last  (w_head.last),
        .o_valid (w_conv_valid),
        .o_data  (w_conv_fp),
        .o_last  (w_conv_last)
    );

    // A converter result is offered to fir_in in the cycle it appears, so an unprimed
    // FIR sees its first sample three edges after the accept
    assign w_stg_valid = (r_state == STAGED) || ((r_state == CONV) && w_conv_valid);
    assign w_stg_fp    = (r_state == STAGED) ? r_stg_fp   : w_conv_fp;
    assign w_stg_last  = (r_state == STAGED) ? r_stg_last : w_conv_last;
    assign w_take      = w_stg_valid && (!r_fir_primed || fir_next);

    // Pop FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pop FSM next state: pop one, wait for the converter, hold until fir_in takes it
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_stage_wr   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = CONV;
                end
            end
            CONV: begin
                if (w_conv_valid) begin
                    if (w_take) begin
                        w_next_state = EMPTY;
                    end else begin
                        w_stage_wr   = 1'b1;
                        w_next_state = STAGED;
                    end
                end
            end
            STAGED: begin
                if (w_take) begin
                    w_next_state = EMPTY;
                end
            end
            default: begin
                w_next_state = EMPTY;
            end
        endcase
    end

    // Staged register holds a converted sample the FIR has not asked for yet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_fp   <= FP_ZERO;
            r_stg_last <= 1'b0;
        end else if (w_stage_wr) begin
            r_stg_fp   <= w_conv_fp;
            r_stg_last <= w_conv_last;
        end
    end

    // fir_in update: prime, advance on fir_next, or feed zeros on underflow and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fir_in     <= FP_ZERO;
            r_fir_stop   <= 1'b0;
            r_fir_primed <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (w_take) begin
            r_fir_in     <= w_stg_fp;
            r_fir_primed <= 1'b1;
            if (w_stg_last) begin
                r_fir_stop <= 1'b1;
            end
        end else if (r_fir_primed && fir_next) begin
            r_fir_in <= FP_ZERO;
            if (!r_fir_stop) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign fir_in     = r_fir_in;
    assign fir_stop   = r_fir_stop;
    assign fir_primed = r_fir_primed;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - randomized self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        fir_next;
    logic [31:0] fir_in;
    logic        fir_stop;
    logic        fir_primed;
    logic [4:0]  fill_level;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];
    bit          m_stop;
    bit          m_under;

    fir_sample_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .fir_next   (fir_next),
        .fir_in     (fir_in),
        .fir_stop   (fir_stop),
        .fir_primed (fir_primed),
        .fill_level (fill_level),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fp(input int v);
        real         r;
        logic [63:0] d;
        int          e;
        if (v == 0) return 32'h0;
        r = v;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        fir_next = 1'b0;
        tick(1);
        check("rst_fill",   32'(fill_level), 0);
        check("rst_primed", 32'(fir_primed), 0);
        check("rst_stop",   32'(fir_stop),   0);
        check("rst_fir_in", fir_in,          0);
        check("rst_uf",     32'(underflow),  0);
        check("rst_ready",  32'(s_ready),    1);
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        m_stop  = 0;
        m_under = 0;
    endtask

    task automatic push(input int v, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = 16'(v);
        s_last  = last;
        while (!s_ready && n < 300) begin
            tick(1);
            n++;
        end
        if (!s_ready) begin
            check("push_timeout", 32'(s_ready), 1);
        end else begin
            tick(1);
            exp_q.push_back({last, ref_fp(v)});
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic take_expect(input string tag);
        logic [32:0] e;
        e = exp_q.pop_front();
        check(tag, fir_in, e[31:0]);
        if (e[32]) m_stop = 1;
    endtask

    task automatic prime_check();
        tick(2);
        check("primed_early", 32'(fir_primed), 0);
        tick(1);
        check("primed", 32'(fir_primed), 1);
        take_expect("prime_in");
    endtask

    task automatic pulse(input string tag);
        fir_next = 1'b1;
        tick(1);
        fir_next = 1'b0;
        if (m_stop) begin
            check(tag, fir_in, 0);
        end else if (exp_q.size() > 0) begin
            take_expect(tag);
        end else begin
            m_under = 1;
            check(tag, fir_in, 0);
        end
        check({tag, "_uf"},   32'(underflow), 32'(m_under));
        check({tag, "_stop"}, 32'(fir_stop),  32'(m_stop));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int k;

        do_reset();
        push(1, 0);
        prime_check();
        push(-1, 0);  tick(7); pulse("t1_m1");
        push(0, 0);   tick(7); pulse("t1_zero");
        push(256, 0); tick(7); pulse("t1_256");

        push(32767, 0);  tick(7); pulse("t2_max");
        check("t2_max_lit", fir_in, 32'h46FF_FE00);
        push(-32768, 0); tick(7); pulse("t2_min");
        check("t2_min_lit", fir_in, 32'hC700_0000);

        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            push(v, 0);
        end
        tick(4);
        check("t3_ready", 32'(s_ready), 0);
        check("t3_fill", 32'(fill_level), DEPTH);
        check("t3_primed", 32'(fir_primed), 1);
        take_expect("t3_first");
        s_valid = 1'b1;
        s_data  = 16'h1234;
        tick(5);
        s_valid = 1'b0;
        check("t3_full_hold", 32'(fill_level), DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick(7);
            pulse("t3_drain");
        end

        tick(7); pulse("t4_empty_a");
        tick(7); pulse("t4_empty_b");
        check("t4_uf_set", 32'(underflow), 1);
        push(100, 0); tick(7); pulse("t4_resume");

        do_reset();
        push(5, 0);
        prime_check();
        push(-7, 0);
        push(1000, 1);
        tick(6); pulse("t5_second");
        tick(7); pulse("t5_last");
        check("t5_stop", 32'(fir_stop), 1);
        check("t5_ready", 32'(s_ready), 0);
        for (int i = 0; i < 9; i++) begin
            tick(7);
            pulse("t5_flush");
        end

        do_reset();
        for (int i = 0; i < 5; i++) push(i * 1111 - 2000, 0);
        tick(1);
        do_reset();
        push(-300, 0);
        prime_check();
        push(77, 0); tick(7); pulse("t6_fresh");

        do_reset();
        push(int'($urandom_range(0, 65535)) - 32768, 0);
        prime_check();
        for (int r = 0; r < 30; r++) begin
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) begin
                v = int'($urandom_range(0, 65535)) - 32768;
                if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 8)) - 4;
                push(v, 0);
                tick(int'($urandom_range(0, 2)));
            end
            tick(6);
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) begin
                tick(7);
                pulse("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
